// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched entries; flush beats push and pop, push into a full queue needs a pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic                                 flush,
    input  fetch_entry_t                         push_entry,
    output fetch_entry_t                         head,
    output logic [$clog2(QUEUE_DEPTH + 1)-1:0]   count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    fetch_entry_t  mem [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(QUEUE_DEPTH));
        do_pop  = pop & !empty;
        do_push = push & (!full | do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, queues words for decode.
// Optional FETCH_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_WIDTH = 10,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        if_fault
);

    localparam int unsigned CW       = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] PC_LIMIT = 32'((64'd1 << IMEM_ADDR_WIDTH) - 64'd4);

    fetch_state_t  state;
    logic [31:0]   pc;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          pop;
    logic          space;
    logic          addr_fault;
    logic          fault_push;
    logic          can_fetch;
    logic          show;

    always_comb begin
        show       = !q_empty & !rst;
        if_valid   = show;
        if_instr   = show ? head.instr : NOP_INSTR;
        if_pc      = show ? head.pc : 32'h0;
        if_fault   = show & head.fault;
        pop        = if_valid & if_ready;
        space      = (q_count < CW'(QUEUE_DEPTH)) | pop;
        addr_fault = (pc[1:0] != 2'b00) | (pc > PC_LIMIT);
        can_fetch  = !rst & !redirect_valid & (state == FETCH) & space;
        imem_req   = can_fetch & !addr_fault;
        fault_push = can_fetch & addr_fault;
        imem_addr  = pc;
        push_entry = fault_push ? '{pc: pc, instr: NOP_INSTR, fault: 1'b1}
                                : '{pc: pc, instr: imem_data, fault: 1'b0};
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (imem_req | fault_push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_entry(push_entry),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Reset beats redirect, redirect beats fetch and fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= FETCH;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= FETCH;
        end else if (imem_req) begin
            pc <= pc + 32'd4;
        end else if (fault_push) begin
            state <= FAULT;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (imem_req) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state == FETCH) && !redirect_valid && q_full && !pop) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_full;
    assign unused_full = q_full;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit with a word-addressed memory model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        chk_addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] mem [256];
    int checks   = 0;
    int failures = 0;
    vec_t vecs [37];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[9:2]];

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .if_fault      (if_fault)
    );

    function automatic vec_t mkv(logic r, logic rv, logic [31:0] rpc, logic rdy, logic req,
                                 logic [31:0] addr, logic ca, logic valid, logic [31:0] pc,
                                 logic [31:0] instr, logic fault);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.req = req; v.addr = addr;
        v.chk_addr = ca; v.valid = valid; v.pc = pc; v.instr = instr; v.fault = fault;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
    endtask

    int waited;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | (i << 2);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        drive(1'b1, 1'b0, 32'h0, 1'b1);

        //              rst rv rpc       rdy req addr      ca valid pc        instr          flt
        vecs[0]  = mkv(1, 0, 32'h0,   1, 0, 32'h0,   1, 0, 32'h0,   NOP,           0);
        vecs[1]  = mkv(0, 0, 32'h0,   1, 1, 32'h0,   1, 0, 32'h0,   NOP,           0);
        vecs[2]  = mkv(0, 0, 32'h0,   1, 1, 32'h4,   1, 1, 32'h0,   32'h0050_0093, 0);
        vecs[3]  = mkv(0, 0, 32'h0,   1, 1, 32'h8,   1, 1, 32'h4,   32'h0010_0113, 0);
        vecs[4]  = mkv(0, 0, 32'h0,   0, 1, 32'hC,   1, 1, 32'h8,   32'hA000_0008, 0);
        vecs[5]  = mkv(0, 0, 32'h0,   0, 0, 32'h10,  1, 1, 32'h8,   32'hA000_0008, 0);
        vecs[6]  = mkv(0, 0, 32'h0,   0, 0, 32'h10,  1, 1, 32'h8,   32'hA000_0008, 0);
        vecs[7]  = mkv(0, 0, 32'h0,   1, 1, 32'h10,  1, 1, 32'h8,   32'hA000_0008, 0);
        vecs[8]  = mkv(0, 0, 32'h0,   1, 1, 32'h14,  1, 1, 32'hC,   32'hA000_000C, 0);
        vecs[9]  = mkv(0, 1, 32'h40,  0, 0, 32'h18,  1, 1, 32'h10,  32'hA000_0010, 0);
        vecs[10] = mkv(0, 0, 32'h0,   1, 1, 32'h40,  1, 0, 32'h0,   NOP,           0);
        vecs[11] = mkv(0, 0, 32'h0,   1, 1, 32'h44,  1, 1, 32'h40,  32'hA000_0040, 0);
        vecs[12] = mkv(0, 1, 32'h42,  1, 0, 32'h48,  1, 1, 32'h44,  32'hA000_0044, 0);
        vecs[13] = mkv(0, 0, 32'h0,   0, 0, 32'h42,  1, 0, 32'h0,   NOP,           0);
        vecs[14] = mkv(0, 0, 32'h0,   0, 0, 32'h42,  1, 1, 32'h42,  NOP,           1);
        vecs[15] = mkv(0, 0, 32'h0,   1, 0, 32'h42,  1, 1, 32'h42,  NOP,           1);
        vecs[16] = mkv(0, 0, 32'h0,   1, 0, 32'h42,  1, 0, 32'h0,   NOP,           0);
        vecs[17] = mkv(0, 0, 32'h0,   1, 0, 32'h42,  1, 0, 32'h0,   NOP,           0);
        vecs[18] = mkv(0, 1, 32'h10,  1, 0, 32'h42,  1, 0, 32'h0,   NOP,           0);
        vecs[19] = mkv(0, 0, 32'h0,   1, 1, 32'h10,  1, 0, 32'h0,   NOP,           0);
        vecs[20] = mkv(0, 0, 32'h0,   1, 1, 32'h14,  1, 1, 32'h10,  32'hA000_0010, 0);
        vecs[21] = mkv(0, 1, 32'h3F8, 1, 0, 32'h18,  1, 1, 32'h14,  32'hA000_0014, 0);
        vecs[22] = mkv(0, 0, 32'h0,   1, 1, 32'h3F8, 1, 0, 32'h0,   NOP,           0);
        vecs[23] = mkv(0, 0, 32'h0,   1, 1, 32'h3FC, 1, 1, 32'h3F8, 32'hA000_03F8, 0);
        vecs[24] = mkv(0, 0, 32'h0,   1, 0, 32'h400, 1, 1, 32'h3FC, 32'hA000_03FC, 0);
        vecs[25] = mkv(0, 0, 32'h0,   1, 0, 32'h400, 1, 1, 32'h400, NOP,           1);
        vecs[26] = mkv(0, 0, 32'h0,   1, 0, 32'h400, 1, 0, 32'h0,   NOP,           0);
        vecs[27] = mkv(0, 1, 32'h0,   0, 0, 32'h400, 1, 0, 32'h0,   NOP,           0);
        vecs[28] = mkv(0, 0, 32'h0,   0, 1, 32'h0,   1, 0, 32'h0,   NOP,           0);
        vecs[29] = mkv(0, 0, 32'h0,   0, 1, 32'h4,   1, 1, 32'h0,   32'h0050_0093, 0);
        vecs[30] = mkv(1, 1, 32'h80,  0, 0, 32'h0,   0, 0, 32'h0,   NOP,           0);
        vecs[31] = mkv(0, 0, 32'h0,   1, 1, 32'h0,   1, 0, 32'h0,   NOP,           0);
        vecs[32] = mkv(0, 0, 32'h0,   1, 1, 32'h4,   1, 1, 32'h0,   32'h0050_0093, 0);
        vecs[33] = mkv(0, 1, 32'h100, 1, 0, 32'h8,   1, 1, 32'h4,   32'h0010_0113, 0);
        vecs[34] = mkv(0, 1, 32'h200, 1, 0, 32'h100, 1, 0, 32'h0,   NOP,           0);
        vecs[35] = mkv(0, 0, 32'h0,   1, 1, 32'h200, 1, 0, 32'h0,   NOP,           0);
        vecs[36] = mkv(0, 0, 32'h0,   1, 1, 32'h204, 1, 1, 32'h200, 32'hA000_0200, 0);

        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].rv, vecs[k].rpc, vecs[k].rdy);
            #1;
            chk("imem_req", k, 32'(imem_req), 32'(vecs[k].req));
            if (vecs[k].chk_addr) chk("imem_addr", k, imem_addr, vecs[k].addr);
            chk("if_valid", k, 32'(if_valid), 32'(vecs[k].valid));
            chk("if_pc", k, if_pc, vecs[k].pc);
            chk("if_instr", k, if_instr, vecs[k].instr);
            chk("if_fault", k, 32'(if_fault), 32'(vecs[k].fault));
`ifdef FETCH_PERF_CNT_EN
            if (k == 31) begin
                chk("perf_fetch_cnt_after_reset", k, perf_fetch_cnt, 32'h0);
                chk("perf_stall_cnt_after_reset", k, perf_stall_cnt, 32'h0);
            end
`endif
        end

        // Redirect latency: target must appear on if_* exactly two cycles later.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h300, 1'b0);
        waited = 0;
        do begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            waited++;
        end while (!if_valid && waited < 8);
        chk("redirect_latency", 100, 32'(waited), 32'd2);
        chk("redirect_if_pc", 100, if_pc, 32'h300);
        chk("redirect_if_instr", 100, if_instr, 32'hA000_0300);

        // Full queue, no pop: fetch must stall with the PC held.
        @(negedge clk);
        #1;
        chk("full_stall_req", 101, 32'(imem_req), 32'd0);
        chk("full_stall_addr", 101, imem_addr, 32'h308);
        chk("full_stall_head", 101, if_pc, 32'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
